// File: rtl/mult_div_pkg.sv
// Shared definitions for the signed multiply/divide controller: FSM states,
// iteration count and the divide-overflow operands.
package mult_div_pkg;

  // Number of Booth / restoring-division iterations per operation.
  localparam int ITER_COUNT = 32;

  // Counter value seen during the final iteration of MULT or DIV.
  localparam logic [5:0] LAST_STEP = 6'(ITER_COUNT - 1);

  // The one signed divide whose true quotient (+2^31) does not fit in 32 bits.
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  // Controller states. Only ST_IDLE accepts a start.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Two's-complement magnitude. INT_MIN maps onto 0x80000000, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  // Two's-complement negate, used for the divide sign correction.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_div_step.sv
// One iteration of unsigned restoring division.
// The accumulator packs {remainder[31:0], quotient/dividend[31:0]}. Each step
// shifts the pair left by one, trial-subtracts the divisor from the widened
// remainder, keeps the difference when it is non-negative and shifts the
// resulting quotient bit into the bottom.
module div_step (
  input  logic [63:0] acc_i,
  input  logic [31:0] divisor_i,
  output logic [63:0] acc_o
);

  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        take;
  logic [31:0] rem_new;

  // Shift, trial subtract, and restore when the trial goes negative.
  always_comb begin
    // Remainder after the left shift needs 33 bits: it can reach 2*divisor-1.
    rem_shift = acc_i[63:31];
    rem_diff  = rem_shift - {1'b0, divisor_i};
    take      = (rem_shift >= {1'b0, divisor_i});
    // Either branch is below the divisor (<= 2^31), so 32 bits suffice.
    rem_new   = take ? rem_diff[31:0] : rem_shift[31:0];
    acc_o     = {rem_new, acc_i[30:0], take};
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply/divide unit producing the Hi/Lo register pair.
//
// Handshake: a start is a single-cycle request honoured only while the unit is
// idle (busy low and not in the DONE cycle); start_mult wins over start_div,
// starts at any other time are dropped, operands are sampled only at the
// accepting edge, busy covers the cycle after acceptance through the DONE
// cycle, and done pulses for exactly one cycle with hi/lo already valid.
//
// Multiply: radix-2 Booth over 32 steps, 33 cycles from acceptance to DONE.
// Divide: restoring division on magnitudes over 32 steps, one FIX cycle for
// sign correction, DONE in cycle 34. Divide by zero goes straight to DONE with
// div_zero set and hi/lo untouched.
module mult_div_ctrl
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;

  // Shared 64-bit accumulator: Booth partial product, or {remainder, quotient}.
  logic [63:0] acc_q, acc_d;

  // Multiply operands: sign-extended multiplicand shifted left each step,
  // multiplier shifted right with the previous LSB kept for Booth recoding.
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        booth_prev_q, booth_prev_d;

  // Divide operands and the sign fix-ups decided at acceptance.
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        ovf_q, ovf_d;

  // Registered outputs.
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [63:0] div_acc_nxt;
  logic [63:0] booth_acc;

  div_step u_div_step (
    .acc_i     (acc_q),
    .divisor_i (divisor_q),
    .acc_o     (div_acc_nxt)
  );

  // Booth recoding of the current multiplier bit pair: 01 adds, 10 subtracts.
  always_comb begin
    booth_acc = acc_q;
    case ({mplier_q[0], booth_prev_q})
      2'b01:   booth_acc = acc_q + mcand_q;
      2'b10:   booth_acc = acc_q - mcand_q;
      default: booth_acc = acc_q;
    endcase
  end

  // Next-state, datapath step and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    booth_prev_d = booth_prev_q;
    divisor_d    = divisor_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    ovf_d        = ovf_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    dz_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_mult) begin
          state_d      = ST_MULT;
          cnt_d        = 6'd0;
          acc_d        = 64'd0;
          mcand_d      = {{32{op_a[31]}}, op_a};
          mplier_d     = op_b;
          booth_prev_d = 1'b0;
        end else if (start_div) begin
          cnt_d = 6'd0;
          if (op_b == 32'd0) begin
            // Nothing to compute: report immediately and keep hi/lo.
            state_d = ST_DONE;
            dz_d    = 1'b1;
          end else begin
            state_d   = ST_DIV;
            acc_d     = {32'd0, abs32(op_a)};
            divisor_d = abs32(op_b);
            neg_quo_d = op_a[31] ^ op_b[31];
            neg_rem_d = op_a[31];
            ovf_d     = (op_a == INT_MIN) && (op_b == NEG_ONE);
          end
        end
      end

      ST_MULT: begin
        acc_d        = booth_acc;
        mcand_d      = {mcand_q[62:0], 1'b0};
        mplier_d     = {mplier_q[31], mplier_q[31:1]};
        booth_prev_d = mplier_q[0];
        cnt_d        = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
          hi_d    = booth_acc[63:32];
          lo_d    = booth_acc[31:0];
        end
      end

      ST_DIV: begin
        acc_d = div_acc_nxt;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        state_d = ST_DONE;
        if (ovf_q) begin
          // Quotient wraps to INT_MIN, remainder is exactly zero, no flag.
          lo_d = INT_MIN;
          hi_d = 32'd0;
        end else begin
          lo_d = neg_quo_q ? neg32(acc_q[31:0])  : acc_q[31:0];
          hi_d = neg_rem_q ? neg32(acc_q[63:32]) : acc_q[63:32];
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 6'd0;
      acc_q        <= 64'd0;
      mcand_q      <= 64'd0;
      mplier_q     <= 32'd0;
      booth_prev_q <= 1'b0;
      divisor_q    <= 32'd0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      ovf_q        <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dz_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      booth_prev_q <= booth_prev_d;
      divisor_q    <= divisor_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      ovf_q        <= ovf_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dz_q         <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
